// File: rtl/task_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : task_dispatcher_pkg
// Description : Shared opcode, completion-status and dispatcher-state
//               definitions plus the packed task descriptor and its
//               legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package task_dispatcher_pkg;

    // Opcodes shared with the instruction scheduler
    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_COMPUTE = 3'b001;
    localparam logic [2:0] OP_STORE   = 3'b010;
    localparam logic [2:0] OP_NOP     = 3'b111;

    // Completion status codes
    localparam logic [1:0] CPL_OK         = 2'b00;
    localparam logic [1:0] CPL_TIMEOUT    = 2'b01;
    localparam logic [1:0] CPL_ILLEGAL_OP = 2'b10;
    localparam logic [1:0] CPL_BAD_LEN    = 2'b11;

    // Dispatcher state encodings
    typedef enum logic [1:0] {
        DSP_IDLE   = 2'd0,
        DSP_ISSUE  = 2'd1,
        DSP_WAIT   = 2'd2,
        DSP_REPORT = 2'd3
    } dsp_state_t;

    // One queued task: id, opcode, src, dst, param1, param2 (163 bits)
    typedef struct packed {
        logic [31:0] task_id;
        logic [2:0]  opcode;
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] param1;
        logic [31:0] param2;
    } task_desc_t;

    localparam int DESC_WIDTH = $bits(task_desc_t);

    // Classify a descriptor; a zero length on LOAD/STORE would underflow
    // the scheduler's length-1 counter, so it is rejected up front.
    function automatic logic [1:0] check_desc(input task_desc_t d);
        logic [1:0] status;
        status = CPL_OK;
        case (d.opcode)
            OP_LOAD, OP_STORE: status = (d.param1 == 32'd0) ? CPL_BAD_LEN : CPL_OK;
            OP_COMPUTE, OP_NOP: status = CPL_OK;
            default:           status = CPL_ILLEGAL_OP;
        endcase
        return status;
    endfunction

endpackage
`default_nettype wire

// File: rtl/task_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : task_dispatcher_if
// Description : Descriptor push, scheduler issue and completion buses of the
//               task dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface task_dispatcher_if;
    // Host descriptor push
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_task_id;
    logic [2:0]  s_opcode;
    logic [31:0] s_src_addr;
    logic [31:0] s_dst_addr;
    logic [31:0] s_param1;
    logic [31:0] s_param2;
    // Scheduler issue
    logic        sched_start;
    logic [31:0] sched_task_id;
    logic [2:0]  sched_opcode;
    logic [31:0] sched_src_addr;
    logic [31:0] sched_dst_addr;
    logic [31:0] sched_param1;
    logic [31:0] sched_param2;
    logic        sched_done;
    // Completion record
    logic        cpl_valid;
    logic        cpl_ready;
    logic [31:0] cpl_task_id;
    logic [1:0]  cpl_status;

    // Dispatcher side
    modport slave (
        input  s_valid, s_task_id, s_opcode, s_src_addr, s_dst_addr, s_param1, s_param2,
        output s_ready,
        output sched_start, sched_task_id, sched_opcode, sched_src_addr, sched_dst_addr,
               sched_param1, sched_param2,
        input  sched_done,
        output cpl_valid, cpl_task_id, cpl_status,
        input  cpl_ready
    );

    // Host / scheduler side
    modport master (
        output s_valid, s_task_id, s_opcode, s_src_addr, s_dst_addr, s_param1, s_param2,
        input  s_ready,
        input  sched_start, sched_task_id, sched_opcode, sched_src_addr, sched_dst_addr,
               sched_param1, sched_param2,
        output sched_done,
        input  cpl_valid, cpl_task_id, cpl_status,
        output cpl_ready
    );
endinterface
`default_nettype wire

// File: rtl/task_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : task_desc_fifo
// Description : Synchronous first-word-fall-through FIFO holding packed task
//               descriptors. Pointers wrap modulo DEPTH (power of two).
// Revision    : 1.0 - initial release
// ============================================================================
module task_desc_fifo #(
    parameter int WIDTH = 163,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_level
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_level = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_level == c_full_level);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (c_ptr_w + 1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - (c_ptr_w + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : task_dispatcher
// Description : Buffers host task descriptors, rejects illegal ones, issues
//               legal ones to the scheduler one at a time under a timeout
//               watchdog and returns a completion record for every task.
// Revision    : 1.0 - initial release
// ============================================================================
module task_dispatcher
    import task_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    task_dispatcher_if.slave            bus,
    output logic                        busy,
    output logic                        halted,
    output logic [$clog2(DEPTH):0]      queue_level
);
    localparam int c_tmr_w = $clog2(TIMEOUT);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    dsp_state_t         r_state;
    task_desc_t         r_desc;
    logic [1:0]         r_status;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_halted;
    logic               r_start;
    logic               r_cpl_valid;
    logic               r_busy;

    task_desc_t         w_push_desc;
    task_desc_t         w_head;
    logic [1:0]         w_head_status;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    // A halted dispatcher refuses new work; no pushes are taken during reset
    assign bus.s_ready   = !w_full && !r_halted && !rst;
    assign w_push        = bus.s_valid && bus.s_ready;
    assign w_pop         = (r_state == DSP_IDLE) && !w_empty && !r_halted;
    assign w_head_status = check_desc(w_head);

    assign w_push_desc = '{
        task_id:  bus.s_task_id,
        opcode:   bus.s_opcode,
        src_addr: bus.s_src_addr,
        dst_addr: bus.s_dst_addr,
        param1:   bus.s_param1,
        param2:   bus.s_param2
    };

    task_desc_fifo #(
        .WIDTH (DESC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_desc),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (queue_level)
    );

    // Descriptor registers only load on a pop, keeping sched_* stable
    assign bus.sched_start    = r_start;
    assign bus.sched_task_id  = r_desc.task_id;
    assign bus.sched_opcode   = r_desc.opcode;
    assign bus.sched_src_addr = r_desc.src_addr;
    assign bus.sched_dst_addr = r_desc.dst_addr;
    assign bus.sched_param1   = r_desc.param1;
    assign bus.sched_param2   = r_desc.param2;
    assign bus.cpl_valid      = r_cpl_valid;
    assign bus.cpl_task_id    = r_desc.task_id;
    assign bus.cpl_status     = r_status;
    assign busy               = r_busy;
    assign halted             = r_halted;

    // Dispatch FSM with registered start/completion/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DSP_IDLE;
            r_desc      <= '0;
            r_status    <= CPL_OK;
            r_timer     <= '0;
            r_halted    <= 1'b0;
            r_start     <= 1'b0;
            r_cpl_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                DSP_IDLE: begin
                    if (w_pop) begin
                        r_desc <= w_head;
                        r_busy <= 1'b1;
                        if (w_head_status == CPL_OK) begin
                            r_state <= DSP_ISSUE;
                            r_start <= 1'b1;
                        end else begin
                            r_state     <= DSP_REPORT;
                            r_status    <= w_head_status;
                            r_cpl_valid <= 1'b1;
                        end
                    end
                end
                DSP_ISSUE: begin
                    r_state <= DSP_WAIT;
                    r_timer <= '0;
                end
                DSP_WAIT: begin
                    // Completion takes priority over a coincident timeout
                    if (bus.sched_done) begin
                        r_state     <= DSP_REPORT;
                        r_status    <= CPL_OK;
                        r_cpl_valid <= 1'b1;
                    end else if (r_timer == c_tmr_last) begin
                        r_state     <= DSP_REPORT;
                        r_status    <= CPL_TIMEOUT;
                        r_cpl_valid <= 1'b1;
                        r_halted    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                DSP_REPORT: begin
                    if (bus.cpl_ready) begin
                        r_state     <= DSP_IDLE;
                        r_cpl_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= DSP_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_task_dispatcher
// Description : Directed scenarios plus randomized traffic for the task
//               dispatcher, compared every cycle against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_task_dispatcher;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       halted;
    logic [2:0] queue_level;

    always #5 clk = ~clk;

    task_dispatcher_if bus();

    task_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .queue_level (queue_level)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] id;
        logic [2:0]  op;
        logic [31:0] src, dst, p1, p2;
    } mdesc_t;

    mdesc_t     mq[$];
    mdesc_t     mcur = '{default: '0};
    mdesc_t     m_nd;
    int         m_phase = 0;   // 0 waiting for work, 1 start pulse, 2 running, 3 reporting
    int         m_left  = 0;   // cycles of patience left while running
    bit         m_halt  = 1'b0;
    bit         m_push_ok;
    logic [1:0] m_st = 2'b00;

    function automatic logic [1:0] classify(input mdesc_t d);
        if (d.op >= 3'd3 && d.op <= 3'd6) return 2'b10;
        if ((d.op == 3'd0 || d.op == 3'd2) && d.p1 == 32'd0) return 2'b11;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mcur    = '{default: '0};
            m_phase = 0;
            m_halt  = 1'b0;
            m_st    = 2'b00;
        end else begin
            m_push_ok = bus.s_valid && (mq.size() < DEPTH) && !m_halt;
            m_nd = '{bus.s_task_id, bus.s_opcode, bus.s_src_addr, bus.s_dst_addr,
                     bus.s_param1, bus.s_param2};
            case (m_phase)
                0: if (mq.size() > 0 && !m_halt) begin
                       mcur    = mq.pop_front();
                       m_st    = classify(mcur);
                       m_phase = (m_st == 2'b00) ? 1 : 3;
                   end
                1: begin m_phase = 2; m_left = TIMEOUT; end
                2: if (bus.sched_done) begin
                       m_st = 2'b00; m_phase = 3;
                   end else begin
                       m_left--;
                       if (m_left == 0) begin m_st = 2'b01; m_halt = 1'b1; m_phase = 3; end
                   end
                3: if (bus.cpl_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
            if (m_push_ok) mq.push_back(m_nd);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("queue_level", queue_level, mq.size());
            if (!rst) chk("s_ready", bus.s_ready, (mq.size() < DEPTH) && !m_halt);
            chk("busy", busy, m_phase != 0);
            chk("halted", halted, m_halt);
            chk("sched_start", bus.sched_start, m_phase == 1);
            chk("cpl_valid", bus.cpl_valid, m_phase == 3);
            if (m_phase == 3) begin
                chk("cpl_task_id", bus.cpl_task_id, mcur.id);
                chk("cpl_status", bus.cpl_status, m_st);
            end
            chk("sched_task_id", bus.sched_task_id, mcur.id);
            chk("sched_opcode", bus.sched_opcode, mcur.op);
            chk("sched_src", bus.sched_src_addr, mcur.src);
            chk("sched_dst", bus.sched_dst_addr, mcur.dst);
            chk("sched_p1", bus.sched_param1, mcur.p1);
            chk("sched_p2", bus.sched_param2, mcur.p2);
        end
    end

    // ---------------- scheduler responder ----------------
    longint cyc = 0;
    longint last_done_cyc = 0;
    int     done_delay = -1;   // cycles from start to done; -1 never
    int     done_cnt   = -1;
    int     done_mode  = 0;    // 0 delayed, 1 random, 2 held high
    int     n_starts   = 0;
    logic   resp_d;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        resp_d = 1'b0;
        if (bus.sched_start) begin
            n_starts++;
            done_cnt = done_delay;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin resp_d = 1'b1; done_cnt = -1; end
        end
        if (done_mode == 1) resp_d = ($urandom_range(0, 5) == 0);
        if (done_mode == 2) resp_d = 1'b1;
        if (resp_d) last_done_cyc = cyc;
        bus.sched_done = resp_d;
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_sig(input int which, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 400) begin
            step();
            n++;
            ok = (which == 0) ? bus.sched_start : bus.cpl_valid;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_bound signal=%0d actual=absent required=seen", which);
        end
    endtask

    task automatic push(input logic [31:0] id, input logic [2:0] op, input logic [31:0] p1);
        int n;
        bus.s_task_id  = id;
        bus.s_opcode   = op;
        bus.s_src_addr = $urandom;
        bus.s_dst_addr = $urandom;
        bus.s_param1   = p1;
        bus.s_param2   = $urandom;
        bus.s_valid    = 1'b1;
        n = 0;
        while (!bus.s_ready && n < 100) begin step(); n++; end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL push_bound actual=not_ready required=ready");
        end
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic get_cpl(input string nm, input logic [31:0] id, input logic [1:0] st);
        int n;
        bit ok;
        if (!bus.cpl_valid) wait_sig(1, n, ok);
        chk({nm, "_id"}, bus.cpl_task_id, id);
        chk({nm, "_status"}, bus.cpl_status, st);
        bus.cpl_ready = 1'b1;
        step();
        bus.cpl_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int     n;
        bit     ok;
        int     starts0;
        int     hc;
        longint s_cyc;

        bus.s_valid = 1'b0; bus.s_task_id = '0; bus.s_opcode = '0;
        bus.s_src_addr = '0; bus.s_dst_addr = '0; bus.s_param1 = '0; bus.s_param2 = '0;
        bus.cpl_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step();
        chk_en = 1'b1;
        chk("rst_level", queue_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpl_valid", bus.cpl_valid, 0);
        rst = 1'b0;
        step();

        // Single COMPUTE, done five cycles after start
        done_delay = 5;
        push(32'h11, 3'b001, 32'd7);
        wait_sig(0, n, ok);
        chk("t1_start_latency", n, 1);
        step();
        chk("t1_single_pulse", bus.sched_start, 0);
        wait_sig(1, n, ok);
        chk("t1_cpl_latency", n, 5);
        get_cpl("t1", 32'h11, 2'b00);
        chk("t1_busy_after", busy, 0);
        chk("t1_cpl_after", bus.cpl_valid, 0);

        // Fill with LOADs while the first one is still running
        done_delay = 12;
        for (int i = 1; i <= 5; i++) push(i, 3'b000, 32'd8);
        chk("t2_full_level", queue_level, 4);
        chk("t2_full_ready", bus.s_ready, 0);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin
                wait_sig(0, n, ok);
                chk("t2_done_to_start", cyc - last_done_cyc, 3);
                chk("t2_issue_id", bus.sched_task_id, i);
            end
            get_cpl("t2", i, 2'b00);
        end

        // Rejects are reported without ever starting the scheduler
        done_delay = 3;
        starts0 = n_starts;
        push(32'd20, 3'b011, 32'd5);
        push(32'd21, 3'b010, 32'd0);
        push(32'd22, 3'b111, 32'd0);
        get_cpl("t3_illegal", 32'd20, 2'b10);
        get_cpl("t3_badlen", 32'd21, 2'b11);
        get_cpl("t3_nop", 32'd22, 2'b00);
        chk("t3_starts", n_starts - starts0, 1);

        // Done on exactly the last allowed cycle wins over timeout
        done_delay = TIMEOUT;
        push(32'd30, 3'b001, 32'd1);
        get_cpl("t5", 32'd30, 2'b00);
        chk("t5_halted", halted, 0);
        done_mode = 2;
        repeat (4) step();
        chk("t5_spurious_cpl", bus.cpl_valid, 0);
        chk("t5_spurious_busy", busy, 0);
        done_mode = 0;
        step();

        // Completion back-pressure, then reset in the middle of a task
        done_delay = 3;
        push(32'h66, 3'b001, 32'd1);
        push(32'h67, 3'b001, 32'd1);
        wait_sig(1, n, ok);
        repeat (10) begin
            step();
            chk("t6_hold_valid", bus.cpl_valid, 1);
            chk("t6_hold_id", bus.cpl_task_id, 32'h66);
            chk("t6_no_start", bus.sched_start, 0);
        end
        chk("t6_level", queue_level, 1);
        done_delay = -1;
        bus.cpl_ready = 1'b1;
        step();
        bus.cpl_ready = 1'b0;
        wait_sig(0, n, ok);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_level", queue_level, 0);
        chk("t6_rst_cpl", bus.cpl_valid, 0);
        chk("t6_rst_start", bus.sched_start, 0);
        chk("t6_rst_id", bus.sched_task_id, 0);
        chk("t6_rst_ready", bus.s_ready, 0);
        rst = 1'b0;
        step();

        // Watchdog timeout halts the dispatcher with work still queued
        done_delay = -1;
        push(32'h40, 3'b001, 32'd1);
        wait_sig(0, n, ok);
        s_cyc = cyc;
        push(32'h41, 3'b001, 32'd1);
        push(32'h42, 3'b001, 32'd1);
        wait_sig(1, n, ok);
        chk("t4_latency", cyc - s_cyc, TIMEOUT + 1);
        chk("t4_status", bus.cpl_status, 2'b01);
        chk("t4_id", bus.cpl_task_id, 32'h40);
        chk("t4_halted", halted, 1);
        chk("t4_ready", bus.s_ready, 0);
        bus.cpl_ready = 1'b1;
        step();
        bus.cpl_ready = 1'b0;
        repeat (5) step();
        chk("t4_retained", queue_level, 2);
        chk("t4_idle", busy, 0);
        chk("t4_still_halted", halted, 1);
        rst = 1'b1;
        step();
        chk("t4_rst_halted", halted, 0);
        rst = 1'b0;
        step();

        // Randomized traffic checked by the model
        done_mode = 1;
        hc = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.s_valid    = $urandom_range(0, 1);
            bus.s_task_id  = $urandom;
            bus.s_opcode   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
                           : (($urandom_range(0, 1) == 0) ? 3'b000 : 3'b001);
            bus.s_src_addr = $urandom;
            bus.s_dst_addr = $urandom;
            bus.s_param1   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            bus.s_param2   = $urandom;
            bus.cpl_ready  = ($urandom_range(0, 2) != 0);
            hc  = halted ? hc + 1 : 0;
            rst = (hc > 30) || ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        bus.s_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound on the whole run
    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time bound reached");
    end

endmodule
`default_nettype wire
